// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object DMA: FSM state encoding and object buffer width.
package jtpopeye_pkg;

   localparam int OBJ_AW = 10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_XFER = 3'd2,
      ST_LAST = 3'd3,
      ST_REL  = 3'd4
   } dma_state_t;

endpackage

// File: rtl/jtpopeye_dma_edge.sv
// Rising-edge detector for a level input, sampled only on clock-enable ticks.
module jtpopeye_dma_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_cen,
   input  logic i_din,
   output logic o_rise
);

   logic r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b0;
      end else if (i_cen) begin
         r_last <= i_din;
      end
   end

   // Pulse is valid only during the cen cycle that first sees the input high.
   assign o_rise = i_cen & i_din & ~r_last;

endmodule

// File: rtl/jtpopeye_dma_ctrl.sv
// Per-frame object DMA sequencer: requests the Z80 bus on VB start and copies LEN+1 bytes.
// Optional REQ timeout enabled by defining JTPOPEYE_DMA_TIMEOUT_EN.
module jtpopeye_dma_ctrl
   import jtpopeye_pkg::*;
#(
   parameter logic [OBJ_AW-1:0] LEN     = 10'd1023,
   parameter logic [7:0]        TIMEOUT = 8'd200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic              VB,
   output logic              busrq_n,
   input  logic              busak_n,
   output logic              dma_cs,
   output logic [OBJ_AW-1:0] AD_DMA,
   input  logic [7:0]        DD_DMA,
   output logic [OBJ_AW-1:0] obj_addr,
   output logic [7:0]        obj_data,
   output logic              obj_we,
   output logic              INITEO,
   output logic              dma_err,
   output dma_state_t        o_state
);

   dma_state_t        r_state, w_state_nx;
   logic              r_busrq_n, w_busrq_n_nx;
   logic              r_cs, w_cs_nx;
   logic [OBJ_AW-1:0] r_ad, w_ad_nx;
   logic [OBJ_AW-1:0] r_obj_addr, w_obj_addr_nx;
   logic [7:0]        r_obj_data, w_obj_data_nx;
   logic              r_we, w_we_nx;
   logic              r_initeo, w_initeo_nx;
   logic              r_err, w_err_nx;
   logic              r_first, w_first_nx;
   logic              w_vb_rise;
   logic              w_timeout;
   logic              w_last_next;

   jtpopeye_dma_edge u_vb_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_cen  (cen),
      .i_din  (VB),
      .o_rise (w_vb_rise)
   );

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
      end else if (cen) begin
         r_cnt <= (r_state == ST_REQ) ? r_cnt + 8'd1 : 8'd0;
      end
   end

   assign w_timeout = (r_cnt == TIMEOUT - 8'd1);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_timeout        = 1'b0;
`endif

   // The first XFER tick only lets DD_DMA settle for address 0; later ticks write the
   // current address and advance, so the address register stops exactly at LEN.
   assign w_last_next = r_first ? (r_ad == LEN) : (r_ad + 10'd1 == LEN);

   // Bus handshake: busrq_n low asks for the bus; busak_n low is the grant. dma_cs is only
   // raised while the grant is held, and the request is dropped before waiting for release.
   always_comb begin
      w_state_nx    = r_state;
      w_busrq_n_nx  = r_busrq_n;
      w_cs_nx       = r_cs;
      w_ad_nx       = r_ad;
      w_obj_addr_nx = r_obj_addr;
      w_obj_data_nx = r_obj_data;
      w_we_nx       = 1'b0;
      w_initeo_nx   = r_initeo;
      w_err_nx      = r_err;
      w_first_nx    = r_first;
      if (cen) begin
         case (r_state)
            ST_IDLE: begin
               if (w_vb_rise) begin
                  w_state_nx   = ST_REQ;
                  w_busrq_n_nx = 1'b0;
                  w_initeo_nx  = 1'b1;
                  w_err_nx     = 1'b0;
               end
            end
            ST_REQ: begin
               if (!busak_n) begin
                  w_state_nx = ST_XFER;
                  w_ad_nx    = '0;
                  w_cs_nx    = 1'b1;
                  w_first_nx = 1'b1;
               end else if (w_timeout) begin
                  w_state_nx   = ST_IDLE;
                  w_busrq_n_nx = 1'b1;
                  w_initeo_nx  = 1'b0;
                  w_err_nx     = 1'b1;
               end
            end
            ST_XFER, ST_LAST: begin
               if (busak_n) begin
                  w_state_nx   = ST_IDLE;
                  w_busrq_n_nx = 1'b1;
                  w_cs_nx      = 1'b0;
                  w_initeo_nx  = 1'b0;
                  w_err_nx     = 1'b1;
               end else if (r_state == ST_LAST) begin
                  w_obj_addr_nx = r_ad;
                  w_obj_data_nx = DD_DMA;
                  w_we_nx       = 1'b1;
                  w_cs_nx       = 1'b0;
                  w_busrq_n_nx  = 1'b1;
                  w_state_nx    = ST_REL;
               end else begin
                  if (!r_first) begin
                     w_obj_addr_nx = r_ad;
                     w_obj_data_nx = DD_DMA;
                     w_we_nx       = 1'b1;
                     w_ad_nx       = r_ad + 10'd1;
                  end
                  w_first_nx = 1'b0;
                  if (w_last_next) w_state_nx = ST_LAST;
               end
            end
            ST_REL: begin
               if (busak_n) begin
                  w_state_nx  = ST_IDLE;
                  w_initeo_nx = 1'b0;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
         if (w_vb_rise && r_state != ST_IDLE) w_err_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_busrq_n  <= 1'b1;
         r_cs       <= 1'b0;
         r_ad       <= '0;
         r_obj_addr <= '0;
         r_obj_data <= 8'd0;
         r_we       <= 1'b0;
         r_initeo   <= 1'b0;
         r_err      <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_busrq_n  <= w_busrq_n_nx;
         r_cs       <= w_cs_nx;
         r_ad       <= w_ad_nx;
         r_obj_addr <= w_obj_addr_nx;
         r_obj_data <= w_obj_data_nx;
         r_we       <= w_we_nx;
         r_initeo   <= w_initeo_nx;
         r_err      <= w_err_nx;
         r_first    <= w_first_nx;
      end
   end

   assign busrq_n  = r_busrq_n;
   assign dma_cs   = r_cs;
   assign AD_DMA   = r_ad;
   assign obj_addr = r_obj_addr;
   assign obj_data = r_obj_data;
   assign obj_we   = r_we;
   assign INITEO   = r_initeo;
   assign dma_err  = r_err;
   assign o_state  = r_state;

endmodule
